multi_digit_seven_segment_scanner: RTL and testbench
====================================================

Name: multi_digit_seven_segment_scanner

Overview:
Time-multiplexed driver for an N-digit common-electrode seven-segment display. It holds a hex word and scans one digit per slot. Each slot has a programmable anti-ghosting blank interval. New words apply only at frame boundaries, so the display never tears. It sits between user logic that produces a value and the board's segment and digit-enable pins.

Parameters:
NUM_DIGITS, 4, number of hex digits (>=1); digit 0 = least significant nibble
CLKS_PER_DIGIT, 25000, clocks per digit slot (>=2)
BLANK_CLKS, 250, clocks at slot start with all digits disabled (0 <= BLANK_CLKS < CLKS_PER_DIGIT)
ACTIVE_LOW, 1, 1 = segment and digit-enable pins active low; 0 = active high

Ports:
i_Clk  in  1  system clock
i_Rst_L  in  1  asynchronous active-low reset
i_Data  in  4*NUM_DIGITS  hex word to display; nibble d feeds digit d
i_Load  in  1  one-cycle strobe; captures i_Data into the pending register
o_Pending  out  1  high while a captured word awaits commit
o_Segments  out  7  bit0=A … bit6=G, polarity per ACTIVE_LOW
o_Digit_En  out  NUM_DIGITS  one-hot (or all-off) digit select, polarity per ACTIVE_LOW
o_Frame_Tick  out  1  one-cycle pulse when the scan wraps to digit 0

Behaviour:
- Clocking and reset: single clock i_Clk. Reset i_Rst_L is asynchronous, active low. All state is cleared on reset.
- Reset values:
  - slot counter = 0, digit index = 0
  - display register = 0, pending register = 0
  - o_Pending = 0, o_Frame_Tick = 0
  - o_Segments all unlit; o_Digit_En all inactive
- Slot counter:
  - counts 0..CLKS_PER_DIGIT-1.
  - At terminal count it returns to 0 and the digit index advances.
  - Digit index wraps from NUM_DIGITS-1 to 0. With NUM_DIGITS=1 it wraps every slot.
- Frame wrap, on the clock edge where the digit index goes to 0:
  - if pending, the display register takes the pending register and o_Pending clears;
  - o_Frame_Tick is high for the following single cycle.
- Load:
  - i_Load=1 writes i_Data to the pending register and sets o_Pending on the next edge.
  - Multiple loads before commit: last wins.
  - Load on the same edge as the wrap: the committed word is the old pending value. The new word goes to pending and o_Pending stays 1.
- Digit enable:
  - For counter < BLANK_CLKS, all digits are inactive.
  - Otherwise only digit [index] is active.
  - Segments are decoded from display-register nibble [index] during the active part of the slot and are all unlit during the blank part.
- Output timing: all outputs are registered. Pin state lags counter/index state by exactly 1 clock.
- Decode (lit segments):
  - 0 ABCDEF, 1 BC, 2 ABDEG, 3 ABCDG
  - 4 BCFG, 5 ACDFG, 6 ACDEFG, 7 ABC
  - 8 ABCDEFG, 9 ABCDFG, A ABCEFG, b CDEFG
  - C ADEF, d BCDEG, E ADEFG, F AEFG
  - Logical "lit"=1 is inverted at the pins when ACTIVE_LOW=1.
- Reset mid-frame: outputs go inactive immediately (asynchronous). After release, the scan restarts at digit 0, counter 0, with the display blank (value 0, shown as "0…0").

Optional Feature:
- Macro: LEADING_ZERO_BLANK_EN.
- Defined: digit d (d>0) is fully unlit when its nibble and all more-significant nibbles are 0. Digit 0 is always shown. The digit enable still asserts normally.
- Undefined: every digit shows its nibble, including leading zeros.

Decomposition:
- Package seven_seg_pkg:
  - 16-entry segment pattern constant table (lit=1, bit0=A);
  - SEG_W=7 constant;
  - function seg_polarity(pattern, active_low).
- Sub-module hex_nibble_to_segments: combinational 4-bit → 7-bit lookup using the package table. It is instanced once, muxed by digit index.
- Counters, wrap and commit logic, and the optional blanking mask stay in the top.

Test Plan:
(All scenarios use NUM_DIGITS=4, CLKS_PER_DIGIT=8, BLANK_CLKS=2, ACTIVE_LOW=1.)
- Reset: assert i_Rst_L=0 mid-slot -> o_Segments=7'b1111111, o_Digit_En=4'b1111 and o_Pending=0 the same cycle. After release, the first enabled digit is digit 0 at cycle 3.
- Load 0x1234 -> o_Pending=1 until wrap. After o_Frame_Tick:
  - digit 0 slot shows o_Digit_En=4'b1110, o_Segments=7'b0011001 ("4");
  - digit 3 shows 7'b1111001 ("1").
- Blank interval: within each slot, o_Digit_En=4'b1111 for 2 cycles, then active for 6 cycles. o_Frame_Tick pulses once every 32 cycles.
- Two loads in one frame (0xAAAA, then 0x00F0) -> only 0x00F0 commits. Digit 1 shows 7'b0001110 ("F").
- Load on the wrap edge -> the old pending value commits, the new value commits one frame later, and o_Pending stays high across the wrap.
- With LEADING_ZERO_BLANK_EN, load 0x0050 -> digits 3 and 2 show 7'b1111111, digit 1 shows 7'b0010010 ("5"), digit 0 shows 7'b1000000 ("0"). Without the macro, digits 3 and 2 show 7'b1000000.

Source files
------------

// File: rtl/seven_seg_pkg.sv
// Shared segment constants for the seven-segment scanner: pattern table
// (lit=1, bit0=A .. bit6=G) and the pin polarity helper.
package seven_seg_pkg;

    localparam int SEG_W = 7;

    // Entry n is the lit pattern for hex digit n; listed from F down to 0.
    localparam logic [15:0][SEG_W-1:0] SEG_TABLE = {
        7'h71, 7'h79, 7'h5E, 7'h39, 7'h7C, 7'h77, 7'h6F, 7'h7F,
        7'h07, 7'h7D, 7'h6D, 7'h66, 7'h4F, 7'h5B, 7'h06, 7'h3F
    };

    function automatic logic [SEG_W-1:0] seg_polarity(
        input logic [SEG_W-1:0] pattern,
        input logic             active_low
    );
        seg_polarity = active_low ? ~pattern : pattern;
    endfunction

endpackage

// File: rtl/hex_nibble_to_segments.sv
// Combinational hex nibble to seven-segment lit pattern lookup.
module hex_nibble_to_segments
    import seven_seg_pkg::*;
(
    input  logic [3:0]       nibble,
    output logic [SEG_W-1:0] pattern
);

    assign pattern = SEG_TABLE[nibble];

endmodule

// File: rtl/multi_digit_seven_segment_scanner.sv
// Time-multiplexed N-digit seven-segment driver with per-slot blanking and
// frame-aligned word commit. Optional macro: LEADING_ZERO_BLANK_EN.
module multi_digit_seven_segment_scanner
    import seven_seg_pkg::*;
#(
    parameter int NUM_DIGITS     = 4,
    parameter int CLKS_PER_DIGIT = 25000,
    parameter int BLANK_CLKS     = 250,
    parameter int ACTIVE_LOW     = 1
) (
    input  logic                    i_Clk,
    input  logic                    i_Rst_L,
    input  logic [4*NUM_DIGITS-1:0] i_Data,
    input  logic                    i_Load,
    output logic                    o_Pending,
    output logic [SEG_W-1:0]        o_Segments,
    output logic [NUM_DIGITS-1:0]   o_Digit_En,
    output logic                    o_Frame_Tick
);

    localparam int DATA_W = 4 * NUM_DIGITS;
    localparam int CNT_W  = $clog2(CLKS_PER_DIGIT);
    localparam int IDX_W  = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
    localparam logic POL  = (ACTIVE_LOW != 0);

    localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(CLKS_PER_DIGIT - 1);
    localparam logic [CNT_W-1:0] CNT_BLANK = CNT_W'(BLANK_CLKS);
    localparam logic [IDX_W-1:0] IDX_LAST  = IDX_W'(NUM_DIGITS - 1);

    logic [CNT_W-1:0]      cnt_r;
    logic [IDX_W-1:0]      idx_r;
    logic [DATA_W-1:0]     disp_r;
    logic [DATA_W-1:0]     pend_data_r;
    logic                  pend_r;
    logic [SEG_W-1:0]      seg_r;
    logic [NUM_DIGITS-1:0] dig_r;
    logic                  tick_r;

    logic [CNT_W-1:0]      cnt_nxt_s;
    logic [IDX_W-1:0]      idx_nxt_s;
    logic                  slot_end_s;
    logic                  wrap_s;
    logic                  blank_s;
    logic                  lzb_s;
    logic [3:0]            nib_s;
    logic [SEG_W-1:0]      dec_s;
    logic [SEG_W-1:0]      seg_lit_s;
    logic [NUM_DIGITS-1:0] dig_lit_s;

    // Slot counter and digit index next-state.
    always_comb begin
        slot_end_s = (cnt_r == CNT_LAST);
        wrap_s     = slot_end_s && (idx_r == IDX_LAST);
        if (slot_end_s) begin
            cnt_nxt_s = {CNT_W{1'b0}};
            idx_nxt_s = (idx_r == IDX_LAST) ? {IDX_W{1'b0}} : idx_r + IDX_W'(1);
        end else begin
            cnt_nxt_s = cnt_r + CNT_W'(1);
            idx_nxt_s = idx_r;
        end
    end

    // Select the display nibble for the digit currently being scanned.
    always_comb begin
        nib_s = 4'h0;
        for (int d = 0; d < NUM_DIGITS; d++) begin
            nib_s = (idx_r == IDX_W'(d)) ? disp_r[d*4 +: 4] : nib_s;
        end
    end

`ifdef LEADING_ZERO_BLANK_EN
    logic zero_above_s;

    // Blank a digit whose nibble and every more-significant nibble are zero.
    always_comb begin
        zero_above_s = 1'b1;
        lzb_s        = 1'b0;
        for (int d = NUM_DIGITS - 1; d > 0; d--) begin
            zero_above_s = zero_above_s & (disp_r[d*4 +: 4] == 4'h0);
            lzb_s        = (idx_r == IDX_W'(d)) ? zero_above_s : lzb_s;
        end
    end
`else
    assign lzb_s = 1'b0;
`endif

    hex_nibble_to_segments u_decode (
        .nibble  (nib_s),
        .pattern (dec_s)
    );

    // Logical (lit=1) pin values for the current counter/index state.
    always_comb begin
        blank_s = (cnt_r < CNT_BLANK);
        if (blank_s) begin
            dig_lit_s = {NUM_DIGITS{1'b0}};
            seg_lit_s = {SEG_W{1'b0}};
        end else begin
            dig_lit_s = NUM_DIGITS'(1) << idx_r;
            seg_lit_s = lzb_s ? {SEG_W{1'b0}} : dec_s;
        end
    end

    // Scan position registers.
    always_ff @(posedge i_Clk or negedge i_Rst_L) begin
        if (!i_Rst_L) begin
            cnt_r <= {CNT_W{1'b0}};
            idx_r <= {IDX_W{1'b0}};
        end else begin
            cnt_r <= cnt_nxt_s;
            idx_r <= idx_nxt_s;
        end
    end

    // Pending capture and frame-aligned commit; a load on the wrap edge
    // lands in pending while the older pending word is committed.
    always_ff @(posedge i_Clk or negedge i_Rst_L) begin
        if (!i_Rst_L) begin
            disp_r      <= {DATA_W{1'b0}};
            pend_data_r <= {DATA_W{1'b0}};
            pend_r      <= 1'b0;
        end else begin
            if (wrap_s && pend_r) begin
                disp_r <= pend_data_r;
            end else begin
                disp_r <= disp_r;
            end
            if (i_Load) begin
                pend_data_r <= i_Data;
                pend_r      <= 1'b1;
            end else if (wrap_s) begin
                pend_data_r <= pend_data_r;
                pend_r      <= 1'b0;
            end else begin
                pend_data_r <= pend_data_r;
                pend_r      <= pend_r;
            end
        end
    end

    // Registered pins, one clock behind the scan state.
    always_ff @(posedge i_Clk or negedge i_Rst_L) begin
        if (!i_Rst_L) begin
            seg_r  <= seg_polarity({SEG_W{1'b0}}, POL);
            dig_r  <= {NUM_DIGITS{POL}};
            tick_r <= 1'b0;
        end else begin
            seg_r  <= seg_polarity(seg_lit_s, POL);
            dig_r  <= dig_lit_s ^ {NUM_DIGITS{POL}};
            tick_r <= wrap_s;
        end
    end

    assign o_Pending    = pend_r;
    assign o_Segments   = seg_r;
    assign o_Digit_En   = dig_r;
    assign o_Frame_Tick = tick_r;

endmodule

// File: tb/tb_multi_digit_seven_segment_scanner.sv
// Directed bench for multi_digit_seven_segment_scanner (4 digits, 8 clks/slot,
// 2 blank clks, active-low pins). Honours LEADING_ZERO_BLANK_EN.
module tb_multi_digit_seven_segment_scanner;

    localparam int ND  = 4;
    localparam int CPD = 8;
    localparam int BLK = 2;

`ifdef LEADING_ZERO_BLANK_EN
    localparam logic [6:0] LZ_SEG = 7'b1111111;
`else
    localparam logic [6:0] LZ_SEG = 7'b1000000;
`endif

    logic          i_Clk;
    logic          i_Rst_L;
    logic [15:0]   i_Data;
    logic          i_Load;
    logic          o_Pending;
    logic [6:0]    o_Segments;
    logic [3:0]    o_Digit_En;
    logic          o_Frame_Tick;

    int n_checks = 0;
    int n_errors = 0;
    int cyc      = 0;

    multi_digit_seven_segment_scanner #(
        .NUM_DIGITS     (ND),
        .CLKS_PER_DIGIT (CPD),
        .BLANK_CLKS     (BLK),
        .ACTIVE_LOW     (1)
    ) dut (
        .i_Clk        (i_Clk),
        .i_Rst_L      (i_Rst_L),
        .i_Data       (i_Data),
        .i_Load       (i_Load),
        .o_Pending    (o_Pending),
        .o_Segments   (o_Segments),
        .o_Digit_En   (o_Digit_En),
        .o_Frame_Tick (o_Frame_Tick)
    );

    initial begin
        i_Clk = 1'b0;
        forever #5 i_Clk = ~i_Clk;
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s @cyc %0d: got %0h expected %0h", tag, cyc, got, exp);
        end
    endtask

    task automatic step();
        @(posedge i_Clk);
        #1;
        cyc++;
    endtask

    task automatic run_to(input int n);
        while (cyc < n) step();
    endtask

    task automatic load_word(input logic [15:0] w);
        i_Data = w;
        i_Load = 1'b1;
        step();
        i_Load = 1'b0;
    endtask

    initial begin
        i_Rst_L = 1'b0;
        i_Data  = 16'h0000;
        i_Load  = 1'b0;
        #20;
        check_eq("rst_seg",  32'(o_Segments),   32'h7F);
        check_eq("rst_dig",  32'(o_Digit_En),   32'hF);
        check_eq("rst_pend", 32'(o_Pending),    32'h0);
        check_eq("rst_tick", 32'(o_Frame_Tick), 32'h0);
        #7;
        i_Rst_L = 1'b1;
        cyc     = 0;

        step();
        check_eq("boot_dig1", 32'(o_Digit_En), 32'hF);
        step();
        check_eq("boot_dig2", 32'(o_Digit_En), 32'hF);
        step();
        check_eq("boot_dig3", 32'(o_Digit_En), 32'hE);
        check_eq("boot_seg3", 32'(o_Segments), 32'h40);

        // 0x1234 captured at edge 4, committed at edge 32.
        load_word(16'h1234);
        check_eq("pend_set", 32'(o_Pending), 32'h1);
        run_to(31);
        check_eq("pend_hold", 32'(o_Pending),    32'h1);
        check_eq("tick_31",   32'(o_Frame_Tick), 32'h0);
        step();
        check_eq("tick_32",   32'(o_Frame_Tick), 32'h1);
        check_eq("pend_clr",  32'(o_Pending),    32'h0);
        step();
        check_eq("tick_33",   32'(o_Frame_Tick), 32'h0);
        run_to(34);
        check_eq("blank_dig", 32'(o_Digit_En), 32'hF);
        check_eq("blank_seg", 32'(o_Segments), 32'h7F);
        step();
        check_eq("d0_dig", 32'(o_Digit_En), 32'hE);
        check_eq("d0_seg", 32'(o_Segments), 32'h19);
        run_to(45);
        check_eq("d1_dig", 32'(o_Digit_En), 32'hD);
        check_eq("d1_seg", 32'(o_Segments), 32'h30);
        run_to(60);
        check_eq("d3_dig", 32'(o_Digit_En), 32'h7);
        check_eq("d3_seg", 32'(o_Segments), 32'h79);
        run_to(63);
        check_eq("tick_63", 32'(o_Frame_Tick), 32'h0);
        step();
        check_eq("tick_64", 32'(o_Frame_Tick), 32'h1);

        // Two loads in one frame: only the last commits at edge 96.
        step();
        load_word(16'hAAAA);
        run_to(70);
        load_word(16'h00F0);
        run_to(96);
        check_eq("ll_tick", 32'(o_Frame_Tick), 32'h1);
        check_eq("ll_pend", 32'(o_Pending),    32'h0);
        run_to(100);
        check_eq("ll_d0", 32'(o_Segments), 32'h40);
        run_to(108);
        check_eq("ll_d1_dig", 32'(o_Digit_En), 32'hD);
        check_eq("ll_d1_seg", 32'(o_Segments), 32'h0E);
        run_to(116);
        check_eq("ll_d2", 32'(o_Segments), 32'(LZ_SEG));
        run_to(119);
        load_word(16'h0050);
        run_to(124);
        check_eq("ll_d3", 32'(o_Segments), 32'(LZ_SEG));

        // Load on the wrap edge 128: 0x0050 commits, 0x0007 stays pending.
        run_to(127);
        load_word(16'h0007);
        check_eq("we_tick", 32'(o_Frame_Tick), 32'h1);
        check_eq("we_pend", 32'(o_Pending),    32'h1);
        run_to(132);
        check_eq("we_d0", 32'(o_Segments), 32'h40);
        run_to(140);
        check_eq("we_d1", 32'(o_Segments), 32'h12);
        run_to(148);
        check_eq("we_d2", 32'(o_Segments), 32'(LZ_SEG));
        run_to(156);
        check_eq("we_d3", 32'(o_Segments), 32'(LZ_SEG));
        run_to(160);
        check_eq("we2_tick", 32'(o_Frame_Tick), 32'h1);
        check_eq("we2_pend", 32'(o_Pending),    32'h0);
        for (int k = 1; k <= CPD; k++) begin
            step();
            check_eq("slot_dig", 32'(o_Digit_En), (k <= BLK) ? 32'hF : 32'hE);
        end
        run_to(164);
        check_eq("we2_d0", 32'(o_Segments), 32'h78);
        run_to(168);
        load_word(16'h1111);
        run_to(172);
        check_eq("we2_d1", 32'(o_Segments), 32'(LZ_SEG));

        // Asynchronous reset while digit 1 is lit and a word is pending.
        run_to(173);
        check_eq("pre_rst_dig",  32'(o_Digit_En), 32'hD);
        check_eq("pre_rst_pend", 32'(o_Pending),  32'h1);
        i_Rst_L = 1'b0;
        #1;
        check_eq("mid_rst_seg",  32'(o_Segments),   32'h7F);
        check_eq("mid_rst_dig",  32'(o_Digit_En),   32'hF);
        check_eq("mid_rst_pend", 32'(o_Pending),    32'h0);
        check_eq("mid_rst_tick", 32'(o_Frame_Tick), 32'h0);
        #1;
        i_Rst_L = 1'b1;
        cyc     = 0;
        step();
        check_eq("re_dig1", 32'(o_Digit_En), 32'hF);
        step();
        check_eq("re_dig2", 32'(o_Digit_En), 32'hF);
        step();
        check_eq("re_dig3", 32'(o_Digit_En), 32'hE);
        check_eq("re_seg3", 32'(o_Segments), 32'h40);
        check_eq("re_pend", 32'(o_Pending),  32'h0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
